// File: rtl/dma_ctrl_pkg.sv
// Shared definitions for the page-copy DMA controller: state encoding,
// default address map and the copy-source address helper.
package dma_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } dma_state_e;

  localparam logic [15:0] TRIG_ADDR_DEF = 16'h4014;
  localparam logic [15:0] DST_ADDR_DEF  = 16'h2004;

  // The source never leaves its page because a transfer is at most 256 bytes.
  function automatic logic [15:0] src_addr(input logic [7:0] page, input logic [8:0] idx);
    return {page, idx[7:0]};
  endfunction

endpackage

// File: rtl/dma_ctrl.sv
// Page-copy DMA controller: passes the MPU bus through to memory when idle and
// takes it over, holding the MPU on RDY, to copy LEN bytes to a destination.
module dma_ctrl
  import dma_ctrl_pkg::*;
#(
  parameter logic [15:0] TRIG_ADDR = TRIG_ADDR_DEF,
  parameter logic [15:0] DST_ADDR  = DST_ADDR_DEF,
  parameter bit          DST_INC   = 1'b0,
  parameter int          LEN       = 256
) (
  input  logic        CLK,
  input  logic        RES_N,
  input  logic [15:0] MPU_AB,
  input  logic        MPU_R_W,
  input  logic [7:0]  MPU_DB_OUT,
  output logic        RDY,
  output logic [15:0] MEM_A,
  output logic        MEM_WE,
  output logic [7:0]  MEM_WD,
  input  logic [7:0]  MEM_RD,
  output logic        BUSY,
  output logic        DONE
);

  localparam logic [8:0] LAST_IDX = 9'(LEN - 1);

  dma_state_e  state_q, state_d;
  logic [8:0]  idx_q, idx_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  data_q, data_d;

  function automatic logic [15:0] dst_addr(input logic [8:0] idx);
    return DST_ADDR + (DST_INC ? 16'(idx) : 16'h0000);
  endfunction

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      page_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      page_q  <= page_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    page_d  = page_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!MPU_R_W && (MPU_AB == TRIG_ADDR)) begin
          page_d  = MPU_DB_OUT;
          idx_d   = '0;
          state_d = ST_ALIGN;
        end
      end
      // A 6502 ignores RDY on write cycles, so wait for it to sit on a read.
      ST_ALIGN: begin
        if (MPU_R_W) state_d = ST_READ;
      end
      ST_READ: begin
        data_d  = MEM_RD;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        idx_d   = idx_q + 9'd1;
        state_d = (idx_q == LAST_IDX) ? ST_IDLE : ST_READ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    RDY    = 1'b1;
    MEM_A  = MPU_AB;
    MEM_WE = ~MPU_R_W;
    MEM_WD = MPU_DB_OUT;
    DONE   = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_ALIGN: RDY = 1'b0;
      ST_READ: begin
        RDY    = 1'b0;
        MEM_A  = src_addr(page_q, idx_q);
        MEM_WE = 1'b0;
      end
      ST_WRITE: begin
        RDY    = 1'b0;
        MEM_A  = dst_addr(idx_q);
        MEM_WE = 1'b1;
        MEM_WD = data_q;
        DONE   = (idx_q == LAST_IDX);
      end
      default: ;
    endcase
  end

  assign BUSY = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dma_ctrl.sv
// Bench: two controllers share one MPU bus model; a scoreboard queue per
// controller holds the expected copy writes, checked by a negedge monitor.
module tb_dma_ctrl;

  logic        CLK = 1'b0;
  logic        RES_N = 1'b0;
  logic [15:0] MPU_AB = 16'h0000;
  logic        MPU_R_W = 1'b1;
  logic [7:0]  MPU_DB_OUT = 8'h00;

  logic        rdy_a, we_a, busy_a, done_a;
  logic [15:0] ma_a;
  logic [7:0]  wd_a, rd_a;
  logic        rdy_b, we_b, busy_b, done_b;
  logic [15:0] ma_b;
  logic [7:0]  wd_b, rd_b;

  logic [7:0]  mem_a [0:65535];
  logic [7:0]  mem_b [0:65535];
  logic        ld_en = 1'b0, ld_sel = 1'b0;
  logic [15:0] ld_addr = 16'h0000;
  logic [7:0]  ld_data = 8'h00;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
    logic        done;
  } wr_t;

  wr_t sb_a[$];
  wr_t sb_b[$];

  int checks = 0, errors = 0;
  int lowcnt_a = 0, lowcnt_b = 0, donecnt_a = 0, donecnt_b = 0, wrcnt_a = 0;

  always #5 CLK = ~CLK;

  dma_ctrl #(.TRIG_ADDR(16'h4014), .DST_ADDR(16'h0400), .DST_INC(1'b1), .LEN(256)) u_dma_a (
    .CLK(CLK), .RES_N(RES_N), .MPU_AB(MPU_AB), .MPU_R_W(MPU_R_W), .MPU_DB_OUT(MPU_DB_OUT),
    .RDY(rdy_a), .MEM_A(ma_a), .MEM_WE(we_a), .MEM_WD(wd_a), .MEM_RD(rd_a),
    .BUSY(busy_a), .DONE(done_a));

  dma_ctrl #(.TRIG_ADDR(16'h4015), .DST_ADDR(16'h2004), .DST_INC(1'b0), .LEN(4)) u_dma_b (
    .CLK(CLK), .RES_N(RES_N), .MPU_AB(MPU_AB), .MPU_R_W(MPU_R_W), .MPU_DB_OUT(MPU_DB_OUT),
    .RDY(rdy_b), .MEM_A(ma_b), .MEM_WE(we_b), .MEM_WD(wd_b), .MEM_RD(rd_b),
    .BUSY(busy_b), .DONE(done_b));

  assign rd_a = mem_a[ma_a];
  assign rd_b = mem_b[ma_b];

  always @(posedge CLK) begin
    if (ld_en && !ld_sel) mem_a[ld_addr] <= ld_data;
    else if (we_a) mem_a[ma_a] <= wd_a;
    if (ld_en && ld_sel) mem_b[ld_addr] <= ld_data;
    else if (we_b) mem_b[ma_b] <= wd_b;
  end

  // Copy writes are the only cycles where RDY is low, the MPU reads and memory is written.
  initial begin
    wr_t e;
    forever begin
      @(negedge CLK);
      if (!rdy_a) lowcnt_a++;
      if (!rdy_b) lowcnt_b++;
      if (done_a) donecnt_a++;
      if (done_b) donecnt_b++;
      if (!rdy_a && we_a && MPU_R_W) begin
        wrcnt_a++;
        checks++;
        if (sb_a.size() == 0) begin
          errors++;
          $display("FAIL dma_wr_a unexpected: a=%h d=%h", ma_a, wd_a);
        end else begin
          e = sb_a.pop_front();
          if (ma_a !== e.a || wd_a !== e.d || done_a !== e.done) begin
            errors++;
            $display("FAIL dma_wr_a: got a=%h d=%h done=%b want a=%h d=%h done=%b",
                     ma_a, wd_a, done_a, e.a, e.d, e.done);
          end
        end
      end
      if (!rdy_b && we_b && MPU_R_W) begin
        checks++;
        if (sb_b.size() == 0) begin
          errors++;
          $display("FAIL dma_wr_b unexpected: a=%h d=%h", ma_b, wd_b);
        end else begin
          e = sb_b.pop_front();
          if (ma_b !== e.a || wd_b !== e.d || done_b !== e.done) begin
            errors++;
            $display("FAIL dma_wr_b: got a=%h d=%h done=%b want a=%h d=%h done=%b",
                     ma_b, wd_b, done_b, e.a, e.d, e.done);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Every bus task starts just after a rising edge and ends on one.
  task automatic load(input logic sel, input logic [15:0] a, input logic [7:0] d);
    #1;
    ld_en = 1'b1; ld_sel = sel; ld_addr = a; ld_data = d;
    @(posedge CLK);
  endtask

  // One MPU bus cycle; a read cycle repeats while RDY is low, as on a 6502.
  task automatic mpu(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                     output logic [7:0] rd);
    logic r;
    int   n;
    n  = 0;
    rd = 8'h00;
    #1;
    ld_en = 1'b0;
    MPU_AB = a; MPU_R_W = rw; MPU_DB_OUT = wd;
    forever begin
      @(negedge CLK);
      r  = rdy_a & rdy_b;
      rd = rd_a;
      @(posedge CLK);
      if (!rw || r) break;
      n++;
      if (n > 3000) begin
        checks++;
        errors++;
        $display("FAIL mpu_halt_timeout: got %0d cycles want at most 3000", n);
        break;
      end
    end
  endtask

  initial begin
    logic [7:0] rv;
    int low0, done0, wr0;
    bit hit;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_rdy_a", 32'(rdy_a), 32'd1);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_pass_a", 32'(ma_a), 32'(MPU_AB));
    chk("rst_rdy_b", 32'(rdy_b), 32'd1);
    RES_N = 1'b1;
    @(posedge CLK);

    for (int i = 0; i < 256; i++) load(1'b0, 16'h0300 + 16'(i), 8'(i) ^ 8'h5A);
    for (int i = 0; i < 16; i++)  load(1'b0, 16'h0500 + 16'(i), 8'(i) ^ 8'hC3);
    load(1'b0, 16'h0000, 8'hA5);
    load(1'b0, 16'h8005, 8'hAD);
    load(1'b0, 16'hFFFC, 8'h00);
    load(1'b0, 16'hFFFD, 8'h80);
    load(1'b1, 16'h0200, 8'h11);
    load(1'b1, 16'h0201, 8'h22);
    load(1'b1, 16'h0202, 8'h33);
    load(1'b1, 16'h0203, 8'h44);

    // Full-page copy with incrementing destination: LDA #$03; STA $4014; LDA $0000
    mpu(16'h8000, 1'b1, 8'h00, rv);
    mpu(16'h8001, 1'b1, 8'h00, rv);
    mpu(16'h8002, 1'b1, 8'h00, rv);
    mpu(16'h8003, 1'b1, 8'h00, rv);
    mpu(16'h8004, 1'b1, 8'h00, rv);
    for (int i = 0; i < 256; i++)
      sb_a.push_back('{a: 16'h0400 + 16'(i), d: 8'(i) ^ 8'h5A, done: (i == 255)});
    low0 = lowcnt_a; done0 = donecnt_a;
    mpu(16'h4014, 1'b0, 8'h03, rv);
    mpu(16'h8005, 1'b1, 8'h00, rv);
    chk("stalled_fetch", 32'(rv), 32'hAD);
    // ALIGN holds RDY low for the one read cycle before the first copy read.
    chk("halt_cycles_a", 32'(lowcnt_a - low0), 32'd513);
    chk("done_pulses_a", 32'(donecnt_a - done0), 32'd1);
    chk("sb_a_drained", 32'(sb_a.size()), 32'd0);
    chk("rdy_after_a", 32'(rdy_a), 32'd1);
    mpu(16'h8006, 1'b1, 8'h00, rv);
    mpu(16'h8007, 1'b1, 8'h00, rv);
    mpu(16'h0000, 1'b1, 8'h00, rv);
    chk("lda_0000", 32'(rv), 32'hA5);
    chk("dst_0400", 32'(mem_a[16'h0400]), 32'h5A);
    chk("dst_04ff", 32'(mem_a[16'h04FF]), 32'hA5);
    chk("dst_0480", 32'(mem_a[16'h0480]), 32'hDA);

    // Four bytes to a fixed destination port
    for (int i = 0; i < 4; i++)
      sb_b.push_back('{a: 16'h2004, d: 8'h11 * 8'(i + 1), done: (i == 3)});
    low0 = lowcnt_b; done0 = donecnt_b;
    mpu(16'h4015, 1'b0, 8'h02, rv);
    mpu(16'h9000, 1'b1, 8'h00, rv);
    chk("halt_cycles_b", 32'(lowcnt_b - low0), 32'd9);
    chk("done_pulses_b", 32'(donecnt_b - done0), 32'd1);
    chk("sb_b_drained", 32'(sb_b.size()), 32'd0);
    chk("port_last", 32'(mem_b[16'h2004]), 32'h44);

    // Trigger followed by stacked pushes, one of them a retrigger attempt
    for (int i = 0; i < 4; i++)
      sb_b.push_back('{a: 16'h2004, d: 8'h11 * 8'(i + 1), done: (i == 3)});
    low0 = lowcnt_b; done0 = donecnt_b;
    mpu(16'h4015, 1'b0, 8'h02, rv);
    mpu(16'h01FD, 1'b0, 8'h12, rv);
    mpu(16'h4015, 1'b0, 8'h07, rv);
    mpu(16'h01FC, 1'b0, 8'h34, rv);
    mpu(16'h9001, 1'b1, 8'h00, rv);
    chk("halt_cycles_push", 32'(lowcnt_b - low0), 32'd12);
    chk("done_pulses_push", 32'(donecnt_b - done0), 32'd1);
    chk("sb_b_push_drained", 32'(sb_b.size()), 32'd0);
    chk("stack_01fd", 32'(mem_b[16'h01FD]), 32'h12);
    chk("stack_01fc", 32'(mem_b[16'h01FC]), 32'h34);
    chk("retrig_write", 32'(mem_b[16'h4015]), 32'h07);
    mpu(16'h9002, 1'b1, 8'h00, rv);
    mpu(16'h9003, 1'b1, 8'h00, rv);
    #1;
    chk("no_retrigger", 32'(busy_b), 32'd0);

    // Asynchronous reset during the write of byte 9
    for (int i = 0; i < 10; i++)
      sb_a.push_back('{a: 16'h0400 + 16'(i), d: 8'(i) ^ 8'hC3, done: 1'b0});
    wr0 = wrcnt_a;
    mpu(16'h4014, 1'b0, 8'h05, rv);
    #1;
    MPU_AB = 16'h8010; MPU_R_W = 1'b1;
    hit = 1'b0;
    for (int n = 0; n < 100 && !hit; n++) begin
      @(negedge CLK);
      #1;
      if (wrcnt_a - wr0 >= 10) hit = 1'b1;
    end
    chk("reach_byte9", 32'(hit), 32'd1);
    RES_N = 1'b0;
    #1;
    chk("async_rdy", 32'(rdy_a), 32'd1);
    chk("async_busy", 32'(busy_a), 32'd0);
    chk("async_done", 32'(done_a), 32'd0);
    chk("async_pass", 32'(ma_a), 32'h8010);
    chk("sb_a_rst_drained", 32'(sb_a.size()), 32'd0);
    @(posedge CLK);
    #1;
    RES_N = 1'b1;
    @(posedge CLK);
    chk("partial_0", 32'(mem_a[16'h0400]), 32'hC3);
    chk("partial_8", 32'(mem_a[16'h0408]), 32'hCB);
    chk("untouched_9", 32'(mem_a[16'h0409]), 32'h53);
    chk("untouched_10", 32'(mem_a[16'h040A]), 32'h50);
    mpu(16'hFFFC, 1'b1, 8'h00, rv);
    chk("vec_lo", 32'(rv), 32'h00);
    mpu(16'hFFFD, 1'b1, 8'h00, rv);
    chk("vec_hi", 32'(rv), 32'h80);

    repeat (2) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
